// File: rtl/mem_addr_sequencer.sv
// Drives ena/wea/memaddr for input, weight and result phases; addresses appear one cycle after the state that issues them.
// Load strobes lag their address by RD_LAT cycles; no backpressure, the sequencer free-runs once a phase starts.
module mem_addr_sequencer #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ADDR_W   = 8,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 16,
    parameter int OUT_BASE = 40,
    parameter int GAP_CYC  = 1,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pixel_finish,
    input  logic              picture_finish,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] memaddr,
    output logic              in_vld,
    output logic              w_vld,
    output logic [3:0]        ld_idx,
    output logic              out_rd,
    output logic [3:0]        out_idx,
    output logic              busy,
    output logic              done
);

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]  N_LAST   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(W_BASE);
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_BASE);

    typedef enum logic [2:0] {
        IDLE, LOAD_IN, GAP, LOAD_W, WAIT_PIX, WRITE_OUT, WAIT_NEXT
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              pend, pend_d;

    logic              ena_d, wea_d, out_rd_d, busy_d, done_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        out_idx_d;
    logic              iss_in_d, iss_w_d, iss_in, iss_w;
    logic [3:0]        iss_idx_d, iss_idx;

    logic [RD_LAT-1:0] in_pipe, w_pipe;
    logic [3:0]        idx_pipe [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pend  <= pend_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pend_d  = pend;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_IN;
                    cnt_d   = '0;
                end
            end
            LOAD_IN: begin
                if (pixel_finish) pend_d = 1'b1;
                if (cnt == N_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYC == 0) ? LOAD_W : GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (pixel_finish) pend_d = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_W;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            LOAD_W: begin
                if (pixel_finish) pend_d = 1'b1;
                if (cnt == N_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_PIX;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_PIX: begin
                if (pixel_finish || pend) begin
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WRITE_OUT;
                end
            end
            WRITE_OUT: begin
                if (cnt == N_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_NEXT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_NEXT: begin
                // End of picture takes priority over a new pixel.
                if (picture_finish) begin
                    state_d = IDLE;
                end else if (start) begin
                    cnt_d   = '0;
                    state_d = LOAD_IN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ena_d     = 1'b0;
        wea_d     = 1'b0;
        out_rd_d  = 1'b0;
        addr_d    = '0;
        out_idx_d = '0;
        iss_in_d  = 1'b0;
        iss_w_d   = 1'b0;
        iss_idx_d = '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state == WAIT_NEXT) && picture_finish;
        case (state)
            LOAD_IN: begin
                ena_d     = 1'b1;
                addr_d    = IN_A + ADDR_W'(cnt);
                iss_in_d  = 1'b1;
                iss_idx_d = cnt[3:0];
            end
            GAP: addr_d = memaddr;
            LOAD_W: begin
                ena_d     = 1'b1;
                addr_d    = W_A + ADDR_W'(cnt);
                iss_w_d   = 1'b1;
                iss_idx_d = cnt[3:0];
            end
            WRITE_OUT: begin
                ena_d     = 1'b1;
                wea_d     = 1'b1;
                out_rd_d  = 1'b1;
                addr_d    = OUT_A + ADDR_W'(cnt);
                out_idx_d = cnt[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ena     <= 1'b0;
            wea     <= 1'b0;
            out_rd  <= 1'b0;
            memaddr <= '0;
            out_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            iss_in  <= 1'b0;
            iss_w   <= 1'b0;
            iss_idx <= '0;
        end else begin
            ena     <= ena_d;
            wea     <= wea_d;
            out_rd  <= out_rd_d;
            memaddr <= addr_d;
            out_idx <= out_idx_d;
            busy    <= busy_d;
            done    <= done_d;
            iss_in  <= iss_in_d;
            iss_w   <= iss_w_d;
            iss_idx <= iss_idx_d;
        end
    end

    // The issue registers line up with memaddr; the pipe adds exactly RD_LAT more cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pipe <= '0;
            w_pipe  <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            in_pipe[0]  <= iss_in;
            w_pipe[0]   <= iss_w;
            idx_pipe[0] <= iss_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                in_pipe[i]  <= in_pipe[i-1];
                w_pipe[i]   <= w_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign in_vld = in_pipe[RD_LAT-1];
    assign w_vld  = w_pipe[RD_LAT-1];
    assign ld_idx = idx_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Directed bench: default instance for read/write sequencing, pending and reset; second instance for RD_LAT=2, no gap, wrapping writes.
module tb_mem_addr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, pixel_finish = 1'b0, picture_finish = 1'b0;
    logic       ena, wea, in_vld, w_vld, out_rd, busy, done;
    logic [7:0] memaddr;
    logic [3:0] ld_idx, out_idx;

    logic       start2 = 1'b0, pixel_finish2 = 1'b0, picture_finish2 = 1'b0;
    logic       ena2, wea2, in_vld2, w_vld2, out_rd2, busy2, done2;
    logic [7:0] memaddr2;
    logic [3:0] ld_idx2, out_idx2;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int addr_e;
    logic ena_e, wea_e, inv_e, wv_e;

    always #5 clk = ~clk;

    mem_addr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pixel_finish(pixel_finish),
        .picture_finish(picture_finish), .ena(ena), .wea(wea), .memaddr(memaddr),
        .in_vld(in_vld), .w_vld(w_vld), .ld_idx(ld_idx), .out_rd(out_rd),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    mem_addr_sequencer #(.RD_LAT(2), .GAP_CYC(0), .OUT_BASE(250)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pixel_finish(pixel_finish2),
        .picture_finish(picture_finish2), .ena(ena2), .wea(wea2), .memaddr(memaddr2),
        .in_vld(in_vld2), .w_vld(w_vld2), .ld_idx(ld_idx2), .out_rd(out_rd2),
        .out_idx(out_idx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ena", 0, 32'(ena), 0);
        check("rst_wea", 0, 32'(wea), 0);
        check("rst_memaddr", 0, 32'(memaddr), 0);
        check("rst_in_vld", 0, 32'(in_vld), 0);
        check("rst_w_vld", 0, 32'(w_vld), 0);
        check("rst_ld_idx", 0, 32'(ld_idx), 0);
        check("rst_out_rd", 0, 32'(out_rd), 0);
        check("rst_out_idx", 0, 32'(out_idx), 0);
        check("rst_busy", 0, 32'(busy), 0);
        check("rst_done", 0, 32'(done), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("idle_ena", 0, 32'(ena), 0);

        // Pixel 1: start ignored mid LOAD_IN and in WRITE_OUT, pixel_finish pending from LOAD_W word 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 51; e++) begin
            tick();
            ena_e  = (e <= 16) || (e >= 18 && e <= 33) || (e >= 35 && e <= 50);
            wea_e  = (e >= 35 && e <= 50);
            inv_e  = (e >= 2 && e <= 17);
            wv_e   = (e >= 19 && e <= 34);
            addr_e = (e <= 16) ? e - 1 : (e == 17) ? 15 : (e <= 33) ? e - 2 :
                     (e == 34) ? 0 : (e <= 50) ? 40 + e - 35 : 0;
            check("p1_memaddr", e, 32'(memaddr), 32'(addr_e));
            check("p1_ena", e, 32'(ena), 32'(ena_e));
            check("p1_wea", e, 32'(wea), 32'(wea_e));
            check("p1_out_rd", e, 32'(out_rd), 32'(wea_e));
            check("p1_in_vld", e, 32'(in_vld), 32'(inv_e));
            check("p1_w_vld", e, 32'(w_vld), 32'(wv_e));
            check("p1_busy", e, 32'(busy), 1);
            if (inv_e) check("p1_ld_idx_in", e, 32'(ld_idx), 32'(e - 2));
            if (wv_e)  check("p1_ld_idx_w", e, 32'(ld_idx), 32'(e - 19));
            if (wea_e) check("p1_out_idx", e, 32'(out_idx), 32'(e - 35));
            if (e == 4)  start = 1'b1;
            if (e == 5)  start = 1'b0;
            if (e == 22) pixel_finish = 1'b1;
            if (e == 23) pixel_finish = 1'b0;
            if (e == 40) start = 1'b1;
            if (e == 41) start = 1'b0;
        end

        // Pixel 2 from WAIT_NEXT; pixel_finish 10 cycles into WAIT_PIX; start+picture_finish together
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            tick();
            ena_e  = (e <= 16) || (e >= 18 && e <= 33) || (e >= 45 && e <= 60);
            wea_e  = (e >= 45 && e <= 60);
            addr_e = (e <= 16) ? e - 1 : (e == 17) ? 15 : (e <= 33) ? e - 2 :
                     (e <= 44) ? 0 : (e <= 60) ? 40 + e - 45 : 0;
            check("p2_memaddr", e, 32'(memaddr), 32'(addr_e));
            check("p2_ena", e, 32'(ena), 32'(ena_e));
            check("p2_wea", e, 32'(wea), 32'(wea_e));
            check("p2_busy", e, 32'(busy), (e <= 61) ? 1 : 0);
            check("p2_done", e, 32'(done), (e == 62) ? 1 : 0);
            if (wea_e) check("p2_out_idx", e, 32'(out_idx), 32'(e - 45));
            if (e == 43) pixel_finish = 1'b1;
            if (e == 44) pixel_finish = 1'b0;
            if (e == 61) begin start = 1'b1; picture_finish = 1'b1; end
            if (e == 62) begin start = 1'b0; picture_finish = 1'b0; end
        end

        // Asynchronous reset during LOAD_W word 7
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 25; e++) tick();
        check("ar_pre_memaddr", 25, 32'(memaddr), 23);
        check("ar_pre_w_vld", 25, 32'(w_vld), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ena", 25, 32'(ena), 0);
        check("ar_memaddr", 25, 32'(memaddr), 0);
        check("ar_w_vld", 25, 32'(w_vld), 0);
        check("ar_ld_idx", 25, 32'(ld_idx), 0);
        check("ar_busy", 25, 32'(busy), 0);
        tick();
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("post_rst_ena", e, 32'(ena), 0);
            check("post_rst_busy", e, 32'(busy), 0);
            check("post_rst_w_vld", e, 32'(w_vld), 0);
        end

        // RD_LAT=2, no gap, result addresses wrap past 255
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 1; e <= 52; e++) begin
            tick();
            ena_e  = (e <= 32) || (e >= 34 && e <= 49);
            wea_e  = (e >= 34 && e <= 49);
            inv_e  = (e >= 3 && e <= 18);
            wv_e   = (e >= 19 && e <= 34);
            addr_e = (e <= 32) ? e - 1 : (e == 33) ? 0 : (e <= 49) ? (250 + e - 34) % 256 : 0;
            check("l2_memaddr", e, 32'(memaddr2), 32'(addr_e));
            check("l2_ena", e, 32'(ena2), 32'(ena_e));
            check("l2_wea", e, 32'(wea2), 32'(wea_e));
            check("l2_in_vld", e, 32'(in_vld2), 32'(inv_e));
            check("l2_w_vld", e, 32'(w_vld2), 32'(wv_e));
            check("l2_done", e, 32'(done2), (e == 51) ? 1 : 0);
            check("l2_busy", e, 32'(busy2), (e <= 50) ? 1 : 0);
            if (inv_e) check("l2_ld_idx_in", e, 32'(ld_idx2), 32'(e - 3));
            if (wv_e)  check("l2_ld_idx_w", e, 32'(ld_idx2), 32'(e - 19));
            if (wea_e) check("l2_out_idx", e, 32'(out_idx2), 32'(e - 34));
            if (e == 5)  pixel_finish2 = 1'b1;
            if (e == 6)  pixel_finish2 = 1'b0;
            if (e == 50) picture_finish2 = 1'b1;
            if (e == 51) picture_finish2 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_addr_sequencer.md
Name: mem_addr_sequencer

Overview:
- Memory-side initiator for the systolic-array controller. It drives ena/wea/memaddr on the shared 8-bit data memory so the testbench no longer has to.
- Read phase: streams ROWS*COLS input words, then ROWS*COLS weight words, with data-valid strobes aligned to memory read latency.
- Write phase: after pixel_finish, writes the controller's ROWS*COLS results back to OUT_BASE.
- Sits between the controller and the memory; it controls addresses and strobes only and never touches data.

Parameters:
- ROWS, 4, array rows
- COLS, 4, array columns; N = ROWS*COLS words per phase
- ADDR_W, 8, memory address width
- IN_BASE, 0, first input-data address
- W_BASE, 16, first weight address
- OUT_BASE, 40, first result address
- GAP_CYC, 1, idle cycles between the input and weight phases (range 0..15)
- RD_LAT, 1, memory read latency in cycles (1 or 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pixel
- pixel_finish  in  1  controller results ready for write-back
- picture_finish  in  1  end of picture; return to IDLE
- ena  out  1  memory enable
- wea  out  1  memory write enable
- memaddr  out  ADDR_W  memory address
- in_vld  out  1  mem_out currently holds input word ld_idx
- w_vld  out  1  mem_out currently holds weight word ld_idx
- ld_idx  out  4  index 0..N-1 of the valid load word
- out_rd  out  1  controller must drive result word out_idx on mem_in this cycle
- out_idx  out  4  result index 0..N-1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on picture completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ena=0, wea=0, memaddr=0, in_vld=0, w_vld=0, ld_idx=0, out_rd=0, out_idx=0, busy=0, done=0; pending flag and counters cleared. Reset mid-phase aborts with no further accesses.
- All outputs are registered.
- States: IDLE, LOAD_IN, GAP, LOAD_W, WAIT_PIX, WRITE_OUT, WAIT_NEXT.
- IDLE: start=1 -> LOAD_IN; the first address appears the next cycle.
- LOAD_IN: ena=1, wea=0, memaddr=IN_BASE+k for k=0..N-1, one word per cycle. After k=N-1 -> GAP, or -> LOAD_W if GAP_CYC=0.
- GAP: ena=0; memaddr holds the last address for GAP_CYC cycles, then -> LOAD_W.
- LOAD_W: memaddr=W_BASE+k for k=0..N-1, one per cycle, ena=1. After the last word -> WAIT_PIX; memaddr=0, ena=0.
- Valid strobes: in_vld/w_vld and ld_idx are the issue pulse and k delayed by exactly RD_LAT cycles through a shift pipeline. Strobes from the final addresses still emerge after the state has left LOAD_IN/LOAD_W.
- WAIT_PIX: ena=0. pixel_finish=1 (or pending flag set) -> WRITE_OUT.
- pixel_finish arriving during LOAD_IN, GAP or LOAD_W sets the pending flag; it is consumed on entry to WAIT_PIX.
- WRITE_OUT: ena=1, wea=1, out_rd=1, memaddr=OUT_BASE+j, out_idx=j for j=0..N-1, one per cycle. Then -> WAIT_NEXT with wea=0, out_rd=0, ena=0, memaddr=0.
- WAIT_NEXT: start -> LOAD_IN (next pixel); picture_finish -> IDLE with done=1 for one cycle.
- If start and picture_finish are both high in WAIT_NEXT, picture_finish wins.
- start is ignored in every state except IDLE and WAIT_NEXT.
- picture_finish is ignored outside WAIT_NEXT.
- pixel_finish is ignored in IDLE, WRITE_OUT and WAIT_NEXT.
- Addresses are computed as base plus a counter, truncated to ADDR_W bits, so they wrap modulo 2^ADDR_W. No overflow flag is raised.
- Per pixel, with start seen at edge 0: 1 + N + GAP_CYC + N cycles of reads, then WAIT_PIX. Defaults: first read address at edge 1, weights at edges 18..33.

Test Plan:
- Reset, then start pulse (defaults) -> memaddr 0..15 on edges 1..16 with ena=1; idle gap on edge 17; 16..31 on edges 18..33; in_vld on edges 2..17 with ld_idx 0..15; w_vld on edges 19..34.
- pixel_finish pulsed during LOAD_W at word 5 -> no write until LOAD_W ends; then wea=1, memaddr 40..55, out_idx 0..15 on 16 consecutive cycles.
- pixel_finish pulsed in WAIT_PIX 10 cycles after entry -> WRITE_OUT begins the next cycle; picture_finish in WAIT_NEXT -> done=1 for exactly one cycle, busy=0.
- start pulsed mid LOAD_IN and again during WRITE_OUT -> ignored, address sequence unchanged; start in WAIT_NEXT -> new pixel from address 0.
- rst driven low at LOAD_W word 7 -> outputs zero asynchronously (before the next edge); after release, no accesses until start.
- RD_LAT=2, GAP_CYC=0, OUT_BASE=250 -> weights follow inputs with no gap; strobes lag addresses by 2 cycles; write addresses 250..255 then 0..9 (wrap).
